// File: rtl/bit16_to_bit8.sv
// bit16_to_bit8: unpacks 16-bit read words into an 8-bit byte stream through a small word FIFO
// and a three-state serializer, ready/valid on both sides.
module bit16_to_bit8 #(
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [15:0]                   bit16_in,
    input  logic                          bit16_in_vld,
    output logic                          bit16_in_rdy,
    output logic [7:0]                    bit8_out,
    output logic                          bit8_out_vld,
    input  logic                          bit8_out_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_EMPTY, S_FIRST, S_SECOND} state_t;

    state_t        r_state;
    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_word;
    logic [7:0]    r_byte;
    logic          r_vld;

    logic          w_full;
    logic          w_empty;
    logic          w_xfer;
    logic          w_push;
    logic          w_pop;
    logic [15:0]   w_head;
    logic [7:0]    w_first;
    logic [7:0]    w_second;

    assign w_full       = r_count == CW'(FIFO_DEPTH);
    assign w_empty      = r_count == '0;
    // Held low during reset so nothing is accepted before the block is live.
    assign bit16_in_rdy = !rst && !w_full;
    assign w_xfer       = r_vld && bit8_out_rdy;
    assign w_push       = bit16_in_vld && bit16_in_rdy && !flush;
    // Popping in SECOND on the last-byte transfer gives back-to-back words with no bubble.
    assign w_pop        = !flush && !w_empty &&
                          (r_state == S_EMPTY || (r_state == S_SECOND && w_xfer));
    assign w_head       = r_mem[r_rd_ptr];
    assign w_first      = MSB_FIRST ? w_head[15:8] : w_head[7:0];
    assign w_second     = MSB_FIRST ? r_word[7:0]  : r_word[15:8];

    assign bit8_out     = r_byte;
    assign bit8_out_vld = r_vld;
    assign fifo_level   = r_count;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bit16_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_word  <= '0;
            r_byte  <= '0;
            r_vld   <= 1'b0;
        end else if (flush) begin
            r_state <= S_EMPTY;
            r_vld   <= 1'b0;
        end else if (w_pop) begin
            r_word  <= w_head;
            r_byte  <= w_first;
            r_vld   <= 1'b1;
            r_state <= S_FIRST;
        end else if (r_state == S_FIRST && w_xfer) begin
            r_byte  <= w_second;
            r_state <= S_SECOND;
        end else if (r_state == S_SECOND && w_xfer) begin
            r_vld   <= 1'b0;
            r_state <= S_EMPTY;
        end
    end
endmodule
